// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
// Column drive patterns, FSM states and scan-result encoding.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIRM,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } scan_res_t;

  localparam logic [1:0] COL_FIRST = 2'd3;

  function automatic logic [3:0] col_drive(
    input logic [1:0] idx
  );
    logic [3:0] pat;
    unique case (idx)
      2'd3:    pat = 4'b0111;
      2'd2:    pat = 4'b1011;
      2'd1:    pat = 4'b1101;
      default: pat = 4'b1110;
    endcase
    return pat;
  endfunction

  function automatic logic one_hot(
    input logic [3:0] v
  );
    return (v != 4'd0) &&
           ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_index(
    input logic [3:0] v
  );
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column scan timing: slot divider plus column index c=3,2,1,0.
// Flags the sampling cycle of each slot and the end of a full scan.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       sample_stb,
  output logic       scan_done
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST =
    DW'(SCAN_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div     <= '0;
      col_idx <= COL_FIRST;
    end else if (div == DIV_LAST) begin
      div     <= '0;
      col_idx <= col_idx - 2'd1;
    end else begin
      div     <= div + DW'(1);
    end
  end

  assign sample_stb = (div == DIV_LAST);
  assign scan_done  = sample_stb &&
                      (col_idx == 2'd0);
  assign col        = col_drive(col_idx);

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: sync, per-scan ghost detection,
// debounce FSM and a valid/ready output with overrun flag.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_LIM =
    CW'(DEBOUNCE_SCANS);

  logic [1:0] col_idx;
  logic       sample_stb;
  logic       scan_done;

  keypad_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .col        (col),
    .col_idx    (col_idx),
    .sample_stb (sample_stb),
    .scan_done  (scan_done)
  );

  logic [3:0] row_meta;
  logic [3:0] row_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  logic [3:0] lows;
  logic       samp_hit;
  logic       samp_one;
  logic [3:0] samp_code;
  logic       hit;
  logic       multi;
  logic [3:0] acc_code;
  logic       cur_hit;
  logic       cur_multi;
  logic [3:0] cur_code;

  assign lows      = ~row_sync;
  assign samp_hit  = sample_stb && (lows != 4'd0);
  assign samp_one  = one_hot(lows);
  assign samp_code = {low_index(lows), col_idx};

  // Two hits, even in different columns, mean a
  // possible ghost and are reported as MULTI.
  assign cur_hit   = hit | samp_hit;
  assign cur_multi = multi |
                     (samp_hit && (!samp_one || hit));
  assign cur_code  = (samp_hit && !hit) ?
                     samp_code : acc_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit      <= 1'b0;
      multi    <= 1'b0;
      acc_code <= 4'd0;
    end else if (scan_done) begin
      hit      <= 1'b0;
      multi    <= 1'b0;
      acc_code <= 4'd0;
    end else if (sample_stb) begin
      hit      <= cur_hit;
      multi    <= cur_multi;
      acc_code <= cur_code;
    end
  end

  scan_res_t res;

  always_comb begin
    res = RES_NONE;
    if (cur_multi)    res = RES_MULTI;
    else if (cur_hit) res = RES_SINGLE;
  end

  state_t        state, state_n;
  logic [3:0]    cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] cnt_inc;
  logic          at_limit;
  logic          single;
  logic          match;
  logic          accept;

  assign single   = (res == RES_SINGLE);
  assign match    = single && (cur_code == cand);
  assign cnt_inc  = cnt + CW'(1);
  assign at_limit = (cnt_inc == DB_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (scan_done) begin
      unique case (state)
        ST_IDLE: begin
          if (single) begin
            cand_n = cur_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_n = ST_PRESSED;
              cnt_n   = '0;
              accept  = 1'b1;
            end else begin
              state_n = ST_CONFIRM;
              cnt_n   = CW'(1);
            end
          end
        end
        ST_CONFIRM: begin
          if (match) begin
            if (at_limit) begin
              state_n = ST_PRESSED;
              cnt_n   = '0;
              accept  = 1'b1;
            end else begin
              cnt_n   = cnt_inc;
            end
          end else if (single) begin
            cand_n = cur_code;
            cnt_n  = CW'(1);
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_PRESSED: begin
          if (!match) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end else begin
              state_n = ST_RELEASE;
              cnt_n   = CW'(1);
            end
          end
        end
        default: begin
          if (match) begin
            state_n = ST_PRESSED;
            cnt_n   = '0;
          end else if (at_limit) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n   = cnt_inc;
          end
        end
      endcase
    end
  end

  assign key_held = (state == ST_PRESSED) ||
                    (state == ST_RELEASE);

  logic hs;
  logic take;
  logic drop;

  assign hs   = key_valid & key_ready;
  assign take = accept && (!key_valid || hs);
  assign drop = accept && key_valid && !hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (take) begin
        key_code  <= cand_n;
        key_valid <= 1'b1;
      end else if (hs) begin
        key_valid <= 1'b0;
      end
      if (drop)    overrun <= 1'b1;
      else if (hs) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with a keypad matrix model
// and a handshake-driven scoreboard of expected key codes.
module tb_hex_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  logic [15:0] mask;
  logic [3:0]  exp_q[$];
  int          n_checks;
  int          n_fail;

  hex_keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key k = 4*r+c pulls row r low while col c is low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Return just after the edge that starts a scan (col=0111).
  task automatic align();
    int b;
    b = 0;
    while (col != 4'b1110 && b < 64) begin
      tick();
      b++;
    end
    while (col != 4'b0111 && b < 64) begin
      tick();
      b++;
    end
    chk("align_in_time", b < 64, 1);
  endtask

  task automatic consume();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && key_valid && key_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected none",
                 key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key_code !== e) begin
          n_fail++;
          $display("FAIL sb_code: got %0h expected %0h",
                   key_code, e);
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    key_ready = 1'b0;
    mask      = 16'h0;

    // 1: reset values and column rotation
    tick(2);
    chk("rst_col", col, 4'b0111);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_code", key_code, 0);
    reset = 1'b0;
    tick(3);
    chk("col_t3", col, 4'b0111);
    tick(1);
    chk("col_t4", col, 4'b1011);
    tick(11);
    chk("col_t15", col, 4'b1110);
    tick(1);
    chk("col_t16", col, 4'b0111);
    chk("idle_valid", key_valid, 0);

    // 2: press 0x9, accept, consume, no repeat, release
    align();
    mask = 16'h1 << 9;
    exp_q.push_back(4'h9);
    tick(47);
    chk("t2_valid_early", key_valid, 0);
    tick(1);
    chk("t2_valid", key_valid, 1);
    chk("t2_code", key_code, 4'h9);
    chk("t2_held", key_held, 1);
    consume();
    chk("t2_valid_clr", key_valid, 0);
    tick(64);
    chk("t2_no_repeat", key_valid, 0);
    chk("t2_held_on", key_held, 1);
    align();
    mask = 16'h0;
    tick(47);
    chk("t2_held_late", key_held, 1);
    tick(1);
    chk("t2_released", key_held, 0);

    // 3: bounce on scan 2 restarts the debounce
    align();
    mask = 16'h1 << 9;
    exp_q.push_back(4'h9);
    tick(16);
    mask = 16'h0;
    tick(16);
    mask = 16'h1 << 9;
    tick(47);
    chk("t3_valid_early", key_valid, 0);
    tick(1);
    chk("t3_valid", key_valid, 1);
    consume();
    mask = 16'h0;
    tick(64);
    chk("t3_released", key_held, 0);

    // 4: two keys together are ignored
    align();
    mask = (16'h1 << 0) | (16'h1 << 5);
    for (int s = 0; s < 10; s++) begin
      tick(16);
      chk("t4_valid", key_valid, 0);
      chk("t4_held", key_held, 0);
      chk("t4_ovr", overrun, 0);
    end
    mask = 16'h0;
    tick(32);

    // 5: second press while first is pending -> overrun
    align();
    mask = 16'h1 << 3;
    exp_q.push_back(4'h3);
    tick(48);
    chk("t5_valid", key_valid, 1);
    chk("t5_code", key_code, 4'h3);
    mask = 16'h0;
    tick(64);
    chk("t5_rel", key_held, 0);
    align();
    mask = 16'h1 << 12;
    tick(47);
    chk("t5_ovr_early", overrun, 0);
    tick(1);
    chk("t5_ovr", overrun, 1);
    chk("t5_code_kept", key_code, 4'h3);
    chk("t5_still_valid", key_valid, 1);
    chk("t5_held_c", key_held, 1);
    consume();
    chk("t5_valid_clr", key_valid, 0);
    chk("t5_ovr_clr", overrun, 0);
    chk("t5_code_hold", key_code, 4'h3);
    mask = 16'h0;
    tick(64);

    // 6: reset in CONFIRM, then a full debounce again
    align();
    mask = 16'h1 << 9;
    tick(37);
    reset = 1'b1;
    #1;
    chk("t6_col", col, 4'b0111);
    chk("t6_code", key_code, 0);
    chk("t6_valid", key_valid, 0);
    chk("t6_held", key_held, 0);
    chk("t6_ovr", overrun, 0);
    tick(2);
    reset = 1'b0;
    exp_q.push_back(4'h9);
    tick(47);
    chk("t6_valid_early", key_valid, 0);
    tick(1);
    chk("t6_valid_after", key_valid, 1);
    chk("t6_code_after", key_code, 4'h9);
    consume();
    mask = 16'h0;
    tick(64);
    chk("t6_rel", key_held, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
